vga_buffer_scanout: RTL and testbench
=====================================

Name: vga_buffer_scanout

Overview:
- Downstream consumer of the 800x480 1-bpp frame buffer filled by the image-generator stage.
- Reads 16-bit buffer words, each holding 16 pixels, in linear address order 0..23999, driven by the display timing generator's frame-start and active-video strobes.
- Serialises each word MSB-first into one pixel per clock and feeds the colour/DAC output stage.
- Double-buffers one word ahead so that the 1-cycle RAM read latency never stalls active video.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- WORD_W, 16, pixels per buffer word; must divide H_ACTIVE.
- ADDR_W, 16, buffer address width.
- WORDS (localparam), H_ACTIVE*V_ACTIVE/WORD_W = 24000, words per frame.

Ports:
- clk  in  1  pixel clock, shared with the buffer read port and the timing generator.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at least 4 cycles before the first active pixel of a frame.
- active  in  1  display-enable from timing; high for exactly one pixel per cycle.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  WORD_W  buffer read data, valid exactly 1 cycle after rd_en.
- pixel  out  1  serialised pixel; 1 = foreground.
- pixel_valid  out  1  qualifies pixel; active delayed 1 cycle.
- underrun  out  1  sticky error flag; cleared on frame_start.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, pixel=0, pixel_valid=0, underrun=0, state=IDLE, shift/prefetch regs=0, prefetch_valid=0, bit_cnt=0.
- State machine:
  - IDLE -> PRIME0 on frame_start.
  - PRIME0: rd_en=1, rd_addr=0 -> PRIME1.
  - PRIME1: rd_en=1, rd_addr=1; capture rd_data (word 0) into shift -> PRIME2.
  - PRIME2: capture word 1 into prefetch, prefetch_valid=1, next read address=2 -> RUN.
  - RUN: stays in RUN until frame_start or reset.
- frame_start in any state, including mid-RUN, restarts at PRIME0 and clears underrun, bit_cnt and prefetch_valid. This takes priority over every other event in the same cycle.
- Pixel datapath, RUN with active=1:
  - Next-cycle pixel = shift[WORD_W-1]; pixel_valid=1 (latency 1 clock from active to pixel).
  - Shift left by 1; bit_cnt++.
- Word boundary, active and bit_cnt==WORD_W-1:
  - shift <= prefetch; prefetch_valid <= 0; bit_cnt <= 0.
  - If next_addr < WORDS: issue rd_en with rd_addr=next_addr, then next_addr++.
  - Returned data next cycle: prefetch <= rd_data, prefetch_valid <= 1.
- active=0 in RUN: shift, bit_cnt and addresses hold; pixel=0; pixel_valid=0. Horizontal and vertical blanking need no special handling because the buffer is linear.
- active=1 while state != RUN: pixel=0, pixel_valid=1, underrun<=1, no reads issued.
- Word boundary with prefetch_valid=0 (should not happen with latency 1): load zeros, set underrun.
- End of frame:
  - After word WORDS-1 is issued, no further reads occur and rd_addr holds at WORDS-1.
  - Active pixels beyond 384000 output 0 and set underrun.
- rd_en is high only in PRIME0, PRIME1 and the boundary read cycles; it is never high two cycles apart within RUN.
- Width rules:
  - next_addr is ADDR_W bits and never wraps; the WORDS bound guarantees this.
  - bit_cnt is clog2(WORD_W) bits and wraps naturally at WORD_W.

Decomposition:
- Shared vga package holds H_ACTIVE/V_ACTIVE constants, WORD_W, WORDS and the state enumeration (IDLE, PRIME0, PRIME1, PRIME2, RUN). The timing generator and image generator use the same constants.
- One natural sub-module: pixel_serializer, covering the shift register, prefetch register, bit_cnt and load-request output. The top level holds the FSM and address counter.

Test Plan:
- Reset, then frame_start, then active held high after 4 cycles. Buffer model: word n = n[15:0]. Required:
  - Reads at addresses 0,1 in consecutive cycles, then address 2 at the first word boundary.
  - First 16 pixels equal 0x0000 bits; pixels 17..32 equal 0x0001, MSB-first (only pixel 32 =1).
  - underrun=0.
- Buffer pattern matching the generator: words with addr%50==0 are 0xFFFF, others 0x0000. Full 800x480 frame with 160 blanking cycles per line. Required:
  - Exactly pixels 0..15 of each line =1.
  - 24000 reads total.
  - Last read address 23999; underrun=0.
- Active asserted 2 cycles after frame_start (during PRIME1) -> pixel=0, pixel_valid=1, underrun=1 until the next frame_start.
- Extra active cycle after pixel 384000 -> pixel=0, underrun=1, no rd_en, rd_addr stays 23999.
- frame_start mid-frame at word 1000, bit 7 -> next reads are addresses 0 then 1; underrun cleared; the first active pixel afterwards is word 0 bit 15.
- reset asserted mid-RUN for 1 cycle -> all outputs at reset values the next cycle; rd_en stays 0 until frame_start.

Source files
------------

// File: rtl/vga_buffer_scanout_pkg.sv
// Shared frame-buffer geometry and scan-out state encoding used by the
// timing generator, the image generator and the scan-out stage.
package vga_buffer_scanout_pkg;

    localparam int FB_H_ACTIVE = 800;
    localparam int FB_V_ACTIVE = 480;
    localparam int FB_WORD_W   = 16;
    localparam int FB_ADDR_W   = 16;
    localparam int FB_WORDS    = FB_H_ACTIVE * FB_V_ACTIVE / FB_WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        PRIME0,
        PRIME1,
        PRIME2,
        RUN
    } scan_state_t;

endpackage

// File: rtl/vga_buffer_scanout_pixel_serializer.sv
// Shift/prefetch pair that turns buffer words into one pixel per clock,
// MSB first, and flags the cycle on which the current word is used up.
module vga_buffer_scanout_pixel_serializer
    import vga_buffer_scanout_pkg::*;
#(
    parameter int WORD_W = FB_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              shift_en,
    input  logic              load_first,
    input  logic              load_prefetch,
    input  logic [WORD_W-1:0] rd_data,
    output logic              pixel_bit,
    output logic              word_done,
    output logic              prefetch_valid
);

    localparam int BIT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] prefetch;
    logic [BIT_W-1:0]  bit_cnt;

    assign pixel_bit = shift[WORD_W-1];
    assign word_done = shift_en && (bit_cnt == BIT_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            shift          <= '0;
            prefetch       <= '0;
            bit_cnt        <= '0;
            prefetch_valid <= 1'b0;
        end else if (restart) begin
            bit_cnt        <= '0;
            prefetch_valid <= 1'b0;
        end else begin
            if (load_first) begin
                shift <= rd_data;
            end else if (word_done) begin
                // a missing prefetch is shown as background rather than stale data
                shift <= prefetch_valid ? prefetch : '0;
            end else if (shift_en) begin
                shift <= {shift[WORD_W-2:0], 1'b0};
            end

            if (word_done) begin
                bit_cnt        <= '0;
                prefetch_valid <= 1'b0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            // returning read data lands after the boundary that emptied prefetch
            if (load_prefetch) begin
                prefetch       <= rd_data;
                prefetch_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_buffer_scanout.sv
// Frame-buffer scan-out: primes two words at frame start, then refills the
// prefetch word at every word boundary while the serializer emits pixels.
//
//   state  | meaning
//   IDLE   | no frame in progress, no reads
//   PRIME0 | read word 0
//   PRIME1 | read word 1, word 0 arrives into shift
//   PRIME2 | word 1 arrives into prefetch
//   RUN    | serialise on active, refill at word boundaries
module vga_buffer_scanout
    import vga_buffer_scanout_pkg::*;
#(
    parameter int H_ACTIVE = FB_H_ACTIVE,
    parameter int V_ACTIVE = FB_V_ACTIVE,
    parameter int WORD_W   = FB_WORD_W,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              active,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              underrun
);

    localparam int WORDS = H_ACTIVE * V_ACTIVE / WORD_W;

    scan_state_t       state;
    logic [ADDR_W-1:0] next_addr;
    logic              rd_pend;
    logic              exhausted;

    logic shift_en;
    logic ser_pixel;
    logic word_done;
    logic prefetch_valid;
    logic load_first;
    logic load_prefetch;

    assign shift_en      = (state == RUN) && active && !frame_start;
    assign load_first    = rd_pend && (state == PRIME1);
    assign load_prefetch = rd_pend && (state != PRIME1);

    vga_buffer_scanout_pixel_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk            (clk),
        .reset          (reset),
        .restart        (frame_start),
        .shift_en       (shift_en),
        .load_first     (load_first),
        .load_prefetch  (load_prefetch),
        .rd_data        (rd_data),
        .pixel_bit      (ser_pixel),
        .word_done      (word_done),
        .prefetch_valid (prefetch_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            next_addr   <= '0;
            rd_pend     <= 1'b0;
            exhausted   <= 1'b0;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            rd_pend     <= rd_en && !frame_start;
            pixel       <= 1'b0;
            pixel_valid <= active;

            if (frame_start) begin
                state     <= PRIME0;
                rd_en     <= 1'b1;
                rd_addr   <= '0;
                next_addr <= '0;
                exhausted <= 1'b0;
                underrun  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    PRIME0: begin
                        state   <= PRIME1;
                        rd_en   <= 1'b1;
                        rd_addr <= ADDR_W'(1);
                    end
                    PRIME1: state <= PRIME2;
                    PRIME2: begin
                        state     <= RUN;
                        next_addr <= ADDR_W'(2);
                    end
                    RUN: begin
                        pixel <= active && !exhausted && ser_pixel;
                        if (word_done) begin
                            if (next_addr < ADDR_W'(WORDS)) begin
                                rd_en     <= 1'b1;
                                rd_addr   <= next_addr;
                                next_addr <= next_addr + ADDR_W'(1);
                            end
                            // an empty prefetch after the final word marks end of frame
                            if (!prefetch_valid) begin
                                if (next_addr == ADDR_W'(WORDS)) begin
                                    exhausted <= 1'b1;
                                end else begin
                                    underrun <= 1'b1;
                                end
                            end
                        end
                        if (active && exhausted) begin
                            underrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (active && (state != RUN)) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_buffer_scanout.sv
// Directed bench for vga_buffer_scanout, using a short 800x24 frame so a
// whole frame plus a long mid-frame restart fit in a modest run.
module tb_vga_buffer_scanout;

    localparam int H  = 800;
    localparam int V  = 24;
    localparam int NW = H * V / 16;
    localparam int NP = H * V;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        active;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        pixel;
    logic        pixel_valid;
    logic        underrun;

    vga_buffer_scanout #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .WORD_W   (16),
        .ADDR_W   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .active      (active),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   mode = 0;
    int   rd_log[$];
    int   rd_cyc[$];
    logic pix_q[$];
    int   pix_cyc[$];

    function automatic logic [15:0] buf_word(input logic [15:0] a);
        case (mode)
            0:       return a;
            1:       return ((a % 16'd50) == 16'd0) ? 16'hFFFF : 16'h0000;
            default: return a ^ 16'h8000;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= buf_word(rd_addr);
    end

    always @(negedge clk) begin
        if (rd_en) begin
            rd_log.push_back(int'(rd_addr));
            rd_cyc.push_back(cyc);
        end
        if (pixel_valid) begin
            pix_q.push_back(pixel);
            pix_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack32(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], pix_q[base + i]};
        return w;
    endfunction

    // frame_start pulse followed by three idle cycles: active may start next
    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
    endtask

    int rb, pb, bad;

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        active      = 1'b0;
        rd_data     = '0;
        repeat (3) tick();
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_pixel", pixel, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        tick();

        // first words of a frame, word n = n
        mode = 0;
        rb = rd_log.size();
        pb = pix_q.size();
        start_frame();
        active = 1'b1;
        repeat (40) tick();
        active = 1'b0;
        repeat (3) tick();
        check("t1_addr0", rd_log[rb], 0);
        check("t1_addr1", rd_log[rb+1], 1);
        check("t1_back_to_back", rd_cyc[rb+1] - rd_cyc[rb], 1);
        check("t1_addr2", rd_log[rb+2], 2);
        check("t1_boundary_time", rd_cyc[rb+2] - rd_cyc[rb], 19);
        check("t1_read_count", rd_log.size() - rb, 4);
        check("t1_pixel_latency", pix_cyc[pb] - rd_cyc[rb], 4);
        check("t1_pixel_count", pix_q.size() - pb, 40);
        check("t1_words01", pack32(pb), 32'h0000_0001);
        check("t1_underrun", underrun, 0);

        // full frame with blanking, generator pattern
        mode = 1;
        rb = rd_log.size();
        pb = pix_q.size();
        start_frame();
        for (int ln = 0; ln < V; ln++) begin
            active = 1'b1;
            repeat (H) tick();
            active = 1'b0;
            repeat (160) tick();
        end
        bad = 0;
        for (int j = 0; j < NP; j++) begin
            if (pix_q[pb + j] !== ((j % H) < 16)) bad++;
        end
        check("t2_pixel_count", pix_q.size() - pb, NP);
        check("t2_pattern_errors", bad, 0);
        check("t2_read_count", rd_log.size() - rb, NW);
        check("t2_last_read", rd_log[rd_log.size()-1], NW - 1);
        check("t2_underrun", underrun, 0);

        // one active pixel past the end of the frame
        active = 1'b1;
        tick();
        active = 1'b0;
        repeat (2) tick();
        check("t4_extra_pixel", pix_q[pb + NP], 0);
        check("t4_underrun", underrun, 1);
        check("t4_no_read", rd_log.size() - rb, NW);
        check("t4_rd_addr_hold", rd_addr, NW - 1);

        // active during PRIME1, then run to word 1000 bit 7
        mode = 2;
        rb = rd_log.size();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        active = 1'b1;
        tick();
        check("t3_early_pixel", pixel, 0);
        check("t3_early_valid", pixel_valid, 1);
        check("t3_early_underrun", underrun, 1);
        active = 1'b0;
        tick();
        active = 1'b1;
        repeat (1000 * 16 + 7) tick();
        active = 1'b0;
        tick();
        check("t3_underrun_sticky", underrun, 1);
        check("t5_reads_before", rd_log.size() - rb, 1002);
        check("t5_last_before", rd_log[rd_log.size()-1], 1001);

        // mid-frame restart
        rb = rd_log.size();
        pb = pix_q.size();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_underrun_cleared", underrun, 0);
        repeat (3) tick();
        active = 1'b1;
        repeat (32) tick();
        active = 1'b0;
        repeat (2) tick();
        check("t5_addr0", rd_log[rb], 0);
        check("t5_addr1", rd_log[rb+1], 1);
        check("t5_back_to_back", rd_cyc[rb+1] - rd_cyc[rb], 1);
        check("t5_pixel_count", pix_q.size() - pb, 32);
        check("t5_words01", pack32(pb), 32'h8000_8001);
        check("t5_underrun", underrun, 0);

        // reset pulse mid-RUN
        active = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        active = 1'b0;
        check("t6_outputs_reset", {11'd0, rd_en, rd_addr, pixel, pixel_valid, underrun}, 0);
        rb = rd_log.size();
        repeat (20) tick();
        check("t6_no_reads_idle", rd_log.size() - rb, 0);
        start_frame();
        check("t6_reads_resume", rd_log.size() - rb, 2);
        check("t6_resume_addr0", rd_log[rb], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
